// File: rtl/tl_pkg.sv
// Shared state codes and light-head encodings for the intersection controller.
package tl_pkg;

  typedef enum logic [2:0] {
    A_GRN   = 3'd0,
    A_YEL   = 3'd1,
    AR_AB   = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    AR_BA   = 3'd5,
    WALK    = 3'd6,
    PED_CLR = 3'd7
  } tl_state_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase tick counter: counts enabled ticks, flags the last tick of a phase.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W:0]   length,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W:0] last;

  assign last = length - 1'b1;
  assign done = ({1'b0, count} == last);

  always_ff @(posedge clk or negedge res) begin
    if (!res)     count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

endmodule

// File: rtl/tl_intersection_ctrl.sv
// Two-approach intersection scheduler with pedestrian walk phase.
module tl_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned GREEN_MIN = 64,
  parameter int unsigned GREEN_MAX = 255,
  parameter int unsigned YELLOW_T  = 32,
  parameter int unsigned ALLRED_T  = 8,
  parameter int unsigned WALK_T    = 48
) (
  input  logic       clk,
  input  logic       res,
  input  logic       en,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
  output logic [2:0] a_lights,
  output logic [2:0] b_lights,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);

  tl_state_e        state, state_next;
  logic             next_b;
  logic [CNT_W:0]   length;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             clr;
  logic             tick_en;

  always_comb begin
    length = (CNT_W+1)'(ALLRED_T);
    unique case (state)
      A_GRN:        length = (CNT_W+1)'(GREEN_MIN);
      B_GRN:        length = (CNT_W+1)'(GREEN_MAX);
      A_YEL, B_YEL: length = (CNT_W+1)'(YELLOW_T);
      WALK:         length = (CNT_W+1)'(WALK_T);
      default:      length = (CNT_W+1)'(ALLRED_T);
    endcase
  end

  // A_GRN rests at its minimum: freezing the count there makes done mean "min reached"
  assign clr     = (state_next != state);
  assign tick_en = en && !(state == A_GRN && done);

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .res    (res),
    .en     (tick_en),
    .clr    (clr),
    .length (length),
    .count  (count),
    .done   (done)
  );

  always_comb begin
    state_next = state;
    if (en) begin
      unique case (state)
        A_GRN:   if (done && (req_b || ped_pending)) state_next = A_YEL;
        A_YEL:   if (done) state_next = AR_AB;
        AR_AB,
        AR_BA:   if (done) state_next = ped_pending ? WALK : (next_b ? B_GRN : A_GRN);
        B_GRN:   if (done || (count >= GMIN_LAST && (!req_b || req_a || ped_pending)))
                   state_next = B_YEL;
        B_YEL:   if (done) state_next = AR_BA;
        WALK:    if (done) state_next = PED_CLR;
        PED_CLR: if (done) state_next = next_b ? B_GRN : A_GRN;
        default: state_next = A_GRN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= A_GRN;
      next_b      <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (state == A_YEL && state_next == AR_AB)      next_b <= 1'b1;
      else if (state == B_YEL && state_next == AR_BA) next_b <= 1'b0;
      if (state != WALK && state_next == WALK) ped_pending <= 1'b0;
      else if (ped_req)                        ped_pending <= 1'b1;
    end
  end

  always_comb begin
    a_lights = LT_RED;
    b_lights = LT_RED;
    walk     = 1'b0;
    phase    = state;
    unique case (state)
      A_GRN:   a_lights = LT_GRN;
      A_YEL:   a_lights = LT_YEL;
      B_GRN:   b_lights = LT_GRN;
      B_YEL:   b_lights = LT_YEL;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tl_intersection_ctrl.sv
// Scoreboard bench: driver predicts each post-edge observation, monitor compares.
module tb_tl_intersection_ctrl;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WLK  = 3;

  logic       clk = 1'b0;
  logic       res, en, req_a, req_b, ped_req;
  logic [2:0] a_lights, b_lights, phase;
  logic       walk, ped_pending;

  tl_intersection_ctrl #(
    .CNT_W     (9),
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YEL),
    .ALLRED_T  (AR),
    .WALK_T    (WLK)
  ) dut (
    .clk         (clk),
    .res         (res),
    .en          (en),
    .req_a       (req_a),
    .req_b       (req_b),
    .ped_req     (ped_req),
    .a_lights    (a_lights),
    .b_lights    (b_lights),
    .walk        (walk),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [10:0]  exp_q[$];
  time          last_ped_t = 0;
  time          last_walk_t = 0;
  bit           any_ped = 0;

  // Reference: phase number, ticks completed in phase, pending ped, "B is owed a green".
  int m_phase, m_age;
  bit m_ped, m_nextb;

  function automatic logic [2:0] head(input int p, input int grn, input int yel);
    if (p == grn)      return 3'b001;
    else if (p == yel) return 3'b010;
    else               return 3'b100;
  endfunction

  function automatic logic [10:0] pack_exp();
    return {3'(m_phase), head(m_phase, 0, 1), head(m_phase, 3, 4),
            (m_phase == 6), m_ped};
  endfunction

  task automatic model_step(input bit r, input bit e, input bit ra, input bit rb, input bit pr);
    int nxt;
    int ticks;
    if (!r) begin
      m_phase = 0; m_age = 0; m_ped = 0; m_nextb = 0;
      return;
    end
    nxt   = m_phase;
    ticks = m_age + 1;
    if (e) begin
      case (m_phase)
        0: if (ticks >= GMIN && (rb || m_ped)) nxt = 1;
        1: if (ticks == YEL) nxt = 2;
        2, 5: if (ticks == AR) nxt = m_ped ? 6 : (m_nextb ? 3 : 0);
        3: if (ticks == GMAX || (ticks >= GMIN && (!rb || ra || m_ped))) nxt = 4;
        4: if (ticks == YEL) nxt = 5;
        6: if (ticks == WLK) nxt = 7;
        7: if (ticks == AR) nxt = m_nextb ? 3 : 0;
        default: nxt = 0;
      endcase
      if (nxt != m_phase) begin
        if (m_phase == 1) m_nextb = 1;
        if (m_phase == 4) m_nextb = 0;
        m_age = 0;
      end else begin
        m_age = (m_phase == 0 && ticks > GMIN - 1) ? GMIN - 1 : ticks;
      end
    end
    m_ped   = (nxt == 6 && m_phase != 6) ? 1'b0 : (m_ped | pr);
    m_phase = nxt;
  endtask

  task automatic cycle(input bit r, input bit e, input bit ra, input bit rb, input bit pr);
    @(negedge clk);
    res = r; en = e; req_a = ra; req_b = rb; ped_req = pr;
    if (pr && r) begin
      last_ped_t = $time;
      any_ped    = 1;
    end
    model_step(r, e, ra, rb, pr);
    exp_q.push_back(pack_exp());
  endtask

  task automatic check_reset_now(input string name);
    logic [10:0] got;
    got = {phase, a_lights, b_lights, walk, ped_pending};
    vectors++;
    if (got !== 11'b000_001_100_0_0) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, 11'b000_001_100_0_0);
    end
  endtask

  // Monitor: every cycle the DUT presents a new light state; check invariants and the scoreboard.
  initial begin
    logic [10:0] got, want;
    forever begin
      @(posedge clk);
      #2;
      got = {phase, a_lights, b_lights, walk, ped_pending};
      if (walk === 1'b1) last_walk_t = $time;
      vectors++;
      if ((a_lights != 3'b100 && b_lights != 3'b100) ||
          (walk && (a_lights != 3'b100 || b_lights != 3'b100)) ||
          $countones(a_lights) != 1 || $countones(b_lights) != 1) begin
        miscompares++;
        $display("FAIL invariant t=%0t a=%b b=%b walk=%b", $time, a_lights, b_lights, walk);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t got ph=%0d a=%b b=%b w=%b pp=%b expected ph=%0d a=%b b=%b w=%b pp=%b",
                   $time, got[10:8], got[7:5], got[4:2], got[1], got[0],
                   want[10:8], want[7:5], want[4:2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    bit reached;
    res = 1'b1; en = 1'b0; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    #1 res = 1'b0;
    #1 check_reset_now("power_on_reset");
    model_step(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // Idle: rests in A_GRN
    repeat (50) cycle(1, 1, 0, 0, 0);

    // B demand with max-out, then return to A
    cycle(0, 1, 0, 0, 0);
    repeat (20) cycle(1, 1, 0, 1, 0);
    repeat (8)  cycle(1, 1, 0, 0, 0);

    // Single ped pulse at A_GRN timer=1, then B gaps out
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    repeat (25) cycle(1, 1, 0, 0, 0);

    // Half-rate tick enable
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 52; i++) cycle(1, (i % 2) == 0, 0, i < 40, 0);

    // Asynchronous reset in the middle of B_YEL
    cycle(0, 1, 0, 0, 0);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cycle(1, 1, 0, 1, 0);
      if (m_phase == 4) reached = 1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL reach_b_yel model phase=%0d required=4", m_phase);
    end
    @(negedge clk);
    #2 res = 1'b0;
    #1 check_reset_now("async_reset_mid_b_yel");
    model_step(0, 0, 0, 0, 0);
    exp_q.push_back(pack_exp());
    cycle(0, 1, 0, 1, 0);
    repeat (30) cycle(1, 1, 0, 1, 0);

    // Random traffic
    cycle(0, 1, 0, 0, 0);
    repeat (10000)
      cycle(1, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
    repeat (80) cycle(1, 1, 0, 0, 0);

    @(posedge clk);
    #3;
    vectors++;
    if (any_ped && (last_walk_t <= last_ped_t || ped_pending !== 1'b0)) begin
      miscompares++;
      $display("FAIL ped_served last_walk=%0t last_ped=%0t pending=%b required walk after ped and pending=0",
               last_walk_t, last_ped_t, ped_pending);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_intersection_ctrl.md
Name: tl_intersection_ctrl

Overview:
- Two-approach intersection scheduler. Shares the crossing between approach A (main road) and approach B (side road), plus a pedestrian walk phase.
- Sequences green, yellow and all-red clearance per approach, with programmable tick-based durations.
- Driven by vehicle sensors and a latched pedestrian request. Drives the light heads directly.

Parameters:
- CNT_W, 9, phase timer width; every duration must be in 1..2^CNT_W.
- GREEN_MIN, 64, minimum green length in ticks, either approach.
- GREEN_MAX, 255, maximum B green length in ticks (forced max-out).
- YELLOW_T, 32, yellow length in ticks.
- ALLRED_T, 8, all-red clearance length in ticks.
- WALK_T, 48, pedestrian walk length in ticks.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- en  in  1  timing tick enable; the timer and state advance only when en=1.
- req_a  in  1  vehicle presence on A, level.
- req_b  in  1  vehicle presence on B, level.
- ped_req  in  1  pedestrian button, pulse or level.
- a_lights  out  3  {red,yellow,green} for A, one-hot.
- b_lights  out  3  {red,yellow,green} for B, one-hot.
- walk  out  1  pedestrian walk indication.
- phase  out  3  current state code.
- ped_pending  out  1  latched pedestrian request.

Behaviour:
- States and codes: A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5, WALK=6, PED_CLR=7.
- Reset (res=0, asynchronous, immediate, also mid-operation):
  - state=A_GRN, timer=0, ped_pending=0, next_b=0.
  - a_lights=001, b_lights=100, walk=0, phase=0.
- Timer:
  - Increments on each clk edge with en=1.
  - Clears to 0 on every state change.
  - Holds when en=0.
  - A state of length N lasts exactly N enabled cycles; it exits on the en=1 edge where timer==N-1.
- Transitions (all qualified by en=1):
  - A_GRN -> A_YEL when timer>=GREEN_MIN-1 and (req_b or ped_pending). Otherwise rest in A_GRN; the timer saturates at GREEN_MIN-1.
  - A_YEL -> AR_AB after YELLOW_T ticks; sets next_b=1.
  - AR_AB or AR_BA, after ALLRED_T ticks:
    - to WALK if ped_pending;
    - else to B_GRN if next_b;
    - else to A_GRN.
  - B_GRN -> B_YEL when either:
    - timer>=GREEN_MIN-1 and (!req_b or req_a or ped_pending) (gap-out / demand), or
    - timer==GREEN_MAX-1 (max-out).
  - B_YEL -> AR_BA after YELLOW_T ticks; sets next_b=0.
  - WALK -> PED_CLR after WALK_T ticks.
  - PED_CLR -> B_GRN if next_b, else A_GRN, after ALLRED_T ticks.
- ped_pending:
  - Set by ped_req on any clk edge, independent of en.
  - Cleared on the edge that enters WALK; the clear wins over a simultaneous ped_req.
  - A ped_req during WALK/PED_CLR re-arms it for the next cycle.
- Outputs are Moore-decoded from the state register and change on the edge after the transition decision.
  - a_lights: 001 in A_GRN, 010 in A_YEL, 100 otherwise.
  - b_lights: 001 in B_GRN, 010 in B_YEL, 100 otherwise.
  - walk=1 only in WALK.
  - phase = state code.
- Safety invariants, every cycle:
  - a_lights and b_lights are never both non-red.
  - walk=1 implies both heads are red.
  - Exactly one bit is set per head.
- Simultaneous req_a and req_b in B_GRN: demand exit at min (req_a wins).

Decomposition:
- Package tl_pkg holds:
  - state codes as localparams/typedef;
  - light encodings LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001.
- One sub-module, tl_phase_timer:
  - CNT_W counter with en and clr inputs;
  - takes a length input and produces a done output when timer==length-1.
- The top level holds the FSM, the ped latch, next_b and the output decode.

Test Plan:
All scenarios use GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1, WALK_T=3, en=1 unless stated.
1. Reset released, no requests for 50 cycles -> phase=0 throughout, a_lights=001, b_lights=100, walk=0.
2. req_b held high from cycle 0, req_a=0 -> A_GRN for 4 cycles, A_YEL 2, AR_AB 1, then B_GRN for 10 (max-out), B_YEL 2, AR_BA 1, then back to A_GRN.
3. One-cycle ped_req at A_GRN timer=1 -> ped_pending=1, then A_YEL, AR_AB, then WALK for 3 cycles with walk=1 and both heads 100; ped_pending=0 from WALK entry; PED_CLR 1, then B_GRN; with req_b=0, B gaps out after 4 cycles.
4. Same stimulus as scenario 2 with en toggling 1,0,1,0 -> every phase lasts twice as many clk cycles; the state sequence is unchanged.
5. res driven low midway through B_YEL, between clock edges -> a_lights=001, b_lights=100, phase=0 without waiting for a clk edge; normal operation resumes after release.
6. 10k cycles of random req_a/req_b/ped_req/en with an invariant checker -> zero safety-invariant violations; every ped_req is followed by a WALK.
